// File: rtl/digit_scan_mux.sv
// Four-digit multiplexed scan driver for a common-anode seven-segment display.
// It snapshots the digits once per frame, blanks the start of each slot, and supports leading-zero blanking.
module digit_scan_mux #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] digits,
  input  logic        lzb_en,
  output logic [3:0]  digit,
  output logic [3:0]  digit_sel,
  output logic        frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] count;
  logic [1:0]    idx;
  logic          running;
  logic [15:0]   snap;
  logic          lzb_snap;

  logic          boundary;
  logic [1:0]    next_idx;
  logic [15:0]   src;
  logic [3:0]    supp;

  // The running flag makes the first edge after reset open slot 0 instead of slot 1.
  always_comb begin
    boundary = !running || (count == LAST);
    next_idx = running ? idx + 2'd1 : 2'd0;
    src      = (next_idx == 2'd0) ? digits : snap;
    supp     = '0;
    supp[1]  = lzb_snap && (snap[15:4]  == 12'h000);
    supp[2]  = lzb_snap && (snap[15:8]  == 8'h00);
    supp[3]  = lzb_snap && (snap[15:12] == 4'h0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      idx         <= 2'd0;
      running     <= 1'b0;
      snap        <= '0;
      lzb_snap    <= 1'b0;
      digit       <= 4'h0;
      digit_sel   <= '1;
      frame_start <= 1'b0;
    end else if (boundary) begin
      count       <= '0;
      idx         <= next_idx;
      running     <= 1'b1;
      if (next_idx == 2'd0) begin
        snap     <= digits;
        lzb_snap <= lzb_en;
      end
      digit       <= src[{next_idx, 2'b00} +: 4];
      digit_sel   <= '1;
      frame_start <= (next_idx == 2'd0);
    end else begin
      count       <= count + CW'(1);
      frame_start <= 1'b0;
      if ((count + CW'(1) == BLANK) && !supp[idx])
        digit_sel <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboarded bench for digit_scan_mux: a frame-arithmetic model pushes the expected
// outputs for every cycle, and a monitor pops and compares them on the falling edge.
module tb_digit_scan_mux;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] digits = 16'h1234;
  logic        lzb_en = 1'b0;
  logic [3:0]  digit;
  logic [3:0]  digit_sel;
  logic        frame_start;

  digit_scan_mux #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset_n(reset_n), .digits(digits), .lzb_en(lzb_en),
    .digit(digit), .digit_sel(digit_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [3:0] d;
    logic [3:0] s;
    logic       f;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  function automatic void chk(string name, int t, logic [3:0] got, logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0d got %h expected %h", name, t, got, want);
    end
  endfunction

  // Reference: the cycle number since the frame began determines the slot and phase; the snapshot is taken at each frame start.
  int          t = 0;
  logic [15:0] msnap = '0;
  logic        mlzb = 1'b0;
  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
      t = 0;
    end else begin
      exp_t e;
      int   slot, c, sh;
      logic sup;
      logic [3:0] m;
      slot = (t / SD) % 4;
      c    = t % SD;
      if (t % FR == 0) begin
        msnap = digits;
        mlzb  = lzb_en;
      end
      sh   = int'(msnap) >> (4 * slot);
      sup  = mlzb && (slot > 0) && (sh == 0);
      m    = 4'(1 << slot);
      e.t  = t;
      e.d  = 4'(sh & 15);
      e.s  = (c < BC || sup) ? 4'hF : ~m;
      e.f  = (t % FR == 0);
      q.push_back(e);
      t++;
    end
  end

  always @(negedge clk) begin
    chk("one_sel", -1, 4'($countones(~digit_sel) <= 1), 4'd1);
    if (!reset_n) begin
      chk("rst_digit", -1, digit, 4'h0);
      chk("rst_sel", -1, digit_sel, 4'hF);
      chk("rst_fs", -1, {3'b0, frame_start}, 4'h0);
    end else if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      pops++;
      chk("digit", e.t, digit, e.d);
      chk("digit_sel", e.t, digit_sel, e.s);
      chk("frame_start", e.t, {3'b0, frame_start}, {3'b0, e.f});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int waited;
    cyc(5);
    #2 reset_n = 1'b1;
    cyc(FR + 10);
    digits = 16'h5678;
    cyc(2 * FR);
    digits = 16'h0070; lzb_en = 1'b1;
    cyc(2 * FR);
    digits = 16'h0000;
    cyc(2 * FR);
    lzb_en = 1'b0;
    cyc(2 * FR);
    digits = 16'h0005;
    cyc(FR + 12);
    lzb_en = 1'b1;
    cyc(2 * FR);
    digits = 16'hABCD; lzb_en = 1'b0;
    cyc(2 * FR);

    waited = 0;
    while (digit_sel === 4'hF && waited < 40) begin
      cyc(1);
      waited++;
    end
    checks++;
    if (waited >= 40) begin
      errors++;
      $display("FAIL show_wait got timeout expected select active");
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async_digit", -1, digit, 4'h0);
    chk("async_sel", -1, digit_sel, 4'hF);
    chk("async_fs", -1, {3'b0, frame_start}, 4'h0);
    cyc(3);
    digits = 16'h9021;
    #2 reset_n = 1'b1;
    cyc(FR + 5);

    for (int i = 0; i < 14; i++) begin
      logic [15:0] v;
      v = '0;
      for (int n = 0; n < 4; n++)
        if ($urandom_range(1, 0) == 1) v[4*n +: 4] = 4'($urandom_range(15, 0));
      digits = v;
      lzb_en = 1'($urandom_range(1, 0));
      cyc($urandom_range(70, 5));
    end
    cyc(2);

    checks++;
    if (pops < 500) begin
      errors++;
      $display("FAIL pop_count got %0d expected at least 500", pops);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
# digit_scan_mux

Time-multiplexed scan driver for a 4-digit common-anode seven-segment display. It snapshots four BCD digits once per frame, presents one digit at a time on a 4-bit `digit` bus, and drives an active-low `digit_sel` strobe for the matching position. It sits directly upstream of `seven_segment_decoder`: `digit` feeds the decoder's `digit` input, and the decoder's `segments` output goes to the shared segment lines. A blanking interval at the start of every slot suppresses ghosting, and optional leading-zero blanking is supported.

## Interface

- `SCAN_DIV`, default 50000: clock cycles per digit slot. Legal range 2 to 2^20. Counter width is clog2(SCAN_DIV).
- `BLANK_CYCLES`, default 500: cycles at the start of each slot with all selects off. Legal range 1 to SCAN_DIV-1.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `digits`  in  16  four digits. [3:0] is position 0 (least significant); [15:12] is position 3.
- `lzb_en`  in  1  leading-zero blanking enable. Sampled with the snapshot.
- `digit`  out  4  value of the current slot's digit, to the decoder.
- `digit_sel`  out  4  active-low position select. Bit i drives position i; at most one bit is low.
- `frame_start`  out  1  one-cycle pulse during the first cycle of slot 0.

## Operation

- **Clock and reset:** one clock. Reset is asynchronous and active-low. All outputs are registered.
- **Slots and frames:**
  - A slot is SCAN_DIV consecutive cycles.
  - A frame is 4 slots, idx 0, 1, 2, 3, then back to 0.
  - The slot counter counts 0 to SCAN_DIV-1 and wraps. idx advances on the wrap, modulo 4.
- **Reset values:**
  - `digit` = 4'h0, `digit_sel` = 4'b1111, `frame_start` = 0.
  - Internal state: idx = 0, count = 0, snapshot = 0, lzb snapshot = 0.
- **Snapshot:**
  - At each edge that begins slot 0, `digits` and `lzb_en` are captured into the snapshot registers.
  - All four slots of a frame display that snapshot. Input changes mid-frame are not shown until the next frame.
- **Per slot, at the edge beginning the slot:**
  - `digit` <= snapshot nibble for idx. For slot 0, this is the newly captured value.
  - `digit_sel` <= 4'b1111.
  - `frame_start` <= (idx == 0).
- **Per slot, at the edge beginning cycle BLANK_CYCLES of the slot:**
  - `digit_sel[idx]` <= 0, unless the position is suppressed.
  - The select holds until the end of the slot.
- **Suppression (leading-zero blanking):**
  - Applies only when the lzb snapshot is 1.
  - Position i (1..3) is suppressed if its nibble and all more-significant nibbles are 4'h0.
  - Position 0 is never suppressed.
  - A suppressed position keeps `digit_sel` = 4'b1111 for its entire slot. `digit` still shows the nibble.
- **Digit values:** nibbles are passed through unmodified. Values 10–15 are not clamped or altered; decoding them is the decoder's concern.
- **Reset mid-operation:** on `reset_n` falling, outputs take reset values immediately, with no clock edge needed. After release, the first rising edge begins slot 0 of a new frame and takes a fresh snapshot.
- **No FSM beyond the counter:** the BLANK/SHOW phase is derived from the slot counter, as `count < BLANK_CYCLES` versus the rest.

## Timing

- Latency from a `digits` change to display is up to one full frame (4·SCAN_DIV cycles) plus 1 cycle.
- `digit` changes only on slot boundaries. It is stable for SCAN_DIV cycles.
- `digit_sel` transitions:
  - It goes high at the slot boundary.
  - It goes low BLANK_CYCLES cycles later.
  - It is never low on the same edge that `digit` changes.
- `frame_start` period is exactly 4·SCAN_DIV cycles. It is high for 1 cycle, coincident with the first cycle of slot 0.
- After reset release, the first rising edge starts slot 0. `frame_start` is high in the cycle that follows that edge.

## Test plan

All scenarios use SCAN_DIV=8 and BLANK_CYCLES=2.

- **Reset:** hold `reset_n` low for 5 cycles -> `digit_sel`=1111, `digit`=0, `frame_start`=0. Drop `reset_n` during a SHOW phase -> outputs return to reset values without a clock edge. After release, slot 0 restarts and `frame_start` pulses on the first cycle.
- **Basic scan:** `digits`=16'h1234, `lzb_en`=0 -> expected outputs per slot:
  - Slot 0: `digit`=4; `digit_sel`=1111 for cycles 0–1, then 1110 for cycles 2–7.
  - Slot 1: `digit`=3, `digit_sel`=1101.
  - Slot 2: `digit`=2, `digit_sel`=1011.
  - Slot 3: `digit`=1, `digit_sel`=0111.
  - `frame_start` is high every 32 cycles.
  - Never more than one `digit_sel` bit is low.
- **Snapshot coherence:** change `digits` from 16'h1234 to 16'h5678 during slot 1 -> slots 1–3 still show 3, 2, 1. The next frame shows 8, 7, 6, 5.
- **Leading-zero blanking:** `digits`=16'h0070, `lzb_en`=1 -> expected outputs per slot:
  - Slots 3 and 2: `digit_sel`=1111 for the whole slot.
  - Slot 1: `digit`=7, `digit_sel`=1101.
  - Slot 0: `digit`=0, `digit_sel`=1110.
  - With `digits`=16'h0000, only slot 0 asserts a select.
  - With `lzb_en`=0, all four positions assert.
- **lzb_en sampling:** toggle `lzb_en` from 0 to 1 mid-frame with `digits`=16'h0005 -> the current frame still shows all positions. Positions 1–3 are blanked from the next frame.
- **Pass-through of non-BCD values:** `digits`=16'hABCD -> `digit` sequence is D, C, B, A, unmodified. Selects behave as in the basic scan.
